// File: rtl/spu_fetch_queue_if.sv
// Fetch-stage bundle: redirect from the branch ALU, instruction-store read port, decode-side head handshake.
// master = fetch queue, slave = surrounding pipe (branch ALU, local store, decode).
interface spu_fetch_queue_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 32
);
  logic               fetch_en;
  logic               branch_taken;
  logic [0:PC_W-1]    branch_target;
  logic               imem_req;
  logic [0:PC_W-1]    imem_addr;
  logic [0:INSTR_W-1] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [0:INSTR_W-1] instr_out;
  logic [0:PC_W-1]    instr_pc;

  modport master (
    input  fetch_en, branch_taken, branch_target, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc
  );

  modport slave (
    output fetch_en, branch_taken, branch_target, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc
  );
endinterface

// File: rtl/spu_fetch_queue.sv
// SPU fetch stage: PC, local-store read issue, QDEPTH-entry {instr,pc} queue to decode, branch redirect/flush.
// Request-to-head 2 edges, redirect-to-head 3 edges; issue is credit-limited so the queue never overflows.
module spu_fetch_queue #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 32,
  parameter int QDEPTH  = 4
) (
  input  logic clk,
  input  logic rst_n,
  spu_fetch_queue_if.master bus
);

  localparam int AW    = $clog2(QDEPTH);
  localparam int CNT_W = AW + 1;
  localparam int CRD_W = AW + 2;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_REDIRECT = 1'b1;

  logic [0:0]         state;
  logic [0:PC_W-1]    fetch_pc;
  logic [0:PC_W-1]    inflight_pc;
  logic               inflight;
  logic               inflight_epoch;
  logic               epoch;
  logic [CNT_W-1:0]   count;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [0:INSTR_W-1] q_instr [QDEPTH];
  logic [0:PC_W-1]    q_pc    [QDEPTH];

  logic               head_vld;
  logic               pop;
  logic               push;
  logic               issue;
  logic [CRD_W-1:0]   credit_used;

  // A head shown during a redirect cycle is never accepted by decode.
  assign head_vld = (count != '0) & ~bus.branch_taken;
  assign pop      = head_vld & bus.instr_ready;
  // Returns tagged with a stale epoch belong to a flushed path.
  assign push     = inflight & (inflight_epoch == epoch);

  // Slots already owned: queued entries plus the read in flight, minus the one leaving now.
  assign credit_used = CRD_W'(count) + CRD_W'(inflight) - CRD_W'(pop);

  always_comb begin
    issue = 1'b0;
    if (rst_n) begin
      if (state == ST_REDIRECT)
        issue = bus.fetch_en;
      else
        issue = bus.fetch_en & ~bus.branch_taken & (credit_used < CRD_W'(QDEPTH));
    end
  end

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = head_vld;
  assign bus.instr_out   = q_instr[rd_ptr];
  assign bus.instr_pc    = q_pc[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_RUN;
      fetch_pc       <= '0;
      inflight_pc    <= '0;
      inflight       <= 1'b0;
      inflight_epoch <= 1'b0;
      epoch          <= 1'b0;
      count          <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc    <= fetch_pc;
        inflight_epoch <= epoch;
        fetch_pc       <= fetch_pc + PC_W'(1);
      end

      if (bus.branch_taken) begin
        // Redirect overrides any issue-side PC advance; the pop and push of this cycle are dropped.
        state    <= ST_REDIRECT;
        epoch    <= ~epoch;
        fetch_pc <= bus.branch_target;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        state <= ST_RUN;
        if (push) begin
          q_instr[wr_ptr] <= bus.imem_rdata;
          q_pc[wr_ptr]    <= inflight_pc;
          wr_ptr          <= wr_ptr + AW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !bus.branch_taken && count == CNT_W'(QDEPTH)));

endmodule

// File: tb/tb_spu_fetch_queue.sv
// Randomized and directed bench for spu_fetch_queue against a queue-based reference model.
module tb_spu_fetch_queue;
  localparam int PC_W    = 10;
  localparam int INSTR_W = 32;
  localparam int QDEPTH  = 4;

  logic clk;
  logic rst_n;

  spu_fetch_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  spu_fetch_queue #(.PC_W(PC_W), .INSTR_W(INSTR_W), .QDEPTH(QDEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: expected queue contents as PCs, one outstanding read, pending-redirect flag.
  logic [0:PC_W-1] mq[$];
  logic [0:PC_W-1] m_pc;
  logic            m_infl;
  logic [0:PC_W-1] m_ipc;
  logic            m_stale;
  logic            m_redir;

  logic            req_q;
  logic [0:PC_W-1] addr_q;

  function automatic logic [0:INSTR_W-1] idata(input logic [0:PC_W-1] pc);
    return {12'hC5A, ~pc, pc};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc    = '0;
    m_infl  = 1'b0;
    m_ipc   = '0;
    m_stale = 1'b0;
    m_redir = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_req"},  32'(bus.imem_req),    32'd0);
    check_eq({tag, "_addr"}, 32'(bus.imem_addr),   32'd0);
    check_eq({tag, "_vld"},  32'(bus.instr_valid), 32'd0);
    check_eq({tag, "_out"},  32'(bus.instr_out),   32'd0);
    check_eq({tag, "_pc"},   32'(bus.instr_pc),    32'd0);
  endtask

  // One clock cycle: entered just after a rising edge, leaves just after the next one.
  task automatic step(input logic fen, input logic rdy, input logic bt, input logic [0:PC_W-1] tgt);
    logic            e_vld, e_pop, e_req;
    logic [0:PC_W-1] cur_pc;
    bus.fetch_en      = fen;
    bus.instr_ready   = rdy;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    #1;
    cur_pc = m_pc;
    e_vld  = (mq.size() != 0) && !bt;
    e_pop  = e_vld && rdy;
    if (m_redir)
      e_req = fen;
    else
      e_req = fen && !bt && (mq.size() + int'(m_infl) - int'(e_pop) < QDEPTH);

    check_eq("imem_req", 32'(bus.imem_req), 32'(e_req));
    if (e_req) check_eq("imem_addr", 32'(bus.imem_addr), 32'(cur_pc));
    check_eq("instr_valid", 32'(bus.instr_valid), 32'(e_vld));
    if (e_vld) begin
      check_eq("instr_pc",  32'(bus.instr_pc),  32'(mq[0]));
      check_eq("instr_out", 32'(bus.instr_out), 32'(idata(mq[0])));
    end

    req_q  = bus.imem_req;
    addr_q = bus.imem_addr;

    if (bt) begin
      mq.delete();
      m_pc    = tgt;
      m_redir = 1'b1;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (m_infl && !m_stale) mq.push_back(m_ipc);
      if (e_req) m_pc = m_pc + PC_W'(1);
      m_redir = 1'b0;
    end
    m_infl  = e_req;
    m_ipc   = cur_pc;
    m_stale = bt;

    @(posedge clk);
    #1;
    bus.imem_rdata = req_q ? idata(addr_q) : INSTR_W'($urandom());
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.fetch_en      = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.instr_ready   = 1'b1;
    bus.imem_rdata    = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Streaming from reset: first head on the third cycle.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Backpressure then release.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++)  step(1'b1, 1'b1, 1'b0, '0);

    // Redirect with queue partly full and a read in flight.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 10'h200);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0);

    // PC wrap 1023 -> 0.
    step(1'b1, 1'b1, 1'b1, 10'd1022);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Back-to-back redirects: latest target wins.
    step(1'b1, 1'b1, 1'b1, 10'h010);
    step(1'b1, 1'b1, 1'b1, 10'h040);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0);

    // fetch_en low: drain, then resume.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Mid-stream reset with a read outstanding; its return must not reach the queue.
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, '0);

    for (int i = 0; i < 1500; i++)
      step(($urandom % 8) != 0, ($urandom % 3) != 0, ($urandom % 12) == 0, PC_W'($urandom));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/spu_fetch_queue.md
# spu_fetch_queue

Instruction fetch stage directly upstream of the SPU branch ALU in the even/odd pipe front end. Owns the 10-bit program counter, issues word reads to instruction local store, buffers returned instructions with their PCs in a small FIFO toward decode, and applies the branch ALU's redirect (`branch_taken`, `PC_result`) by flushing buffered and in-flight fetches and restarting at the target.

## Interface
- `PC_W`, 10, program counter width (word address)
- `INSTR_W`, 32, instruction width
- `QDEPTH`, 4, fetch queue entries (power of two, ≥2)

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `fetch_en`  in  1  permits new fetch requests
- `branch_taken`  in  1  redirect strobe from branch ALU
- `branch_target`  in  [0:PC_W-1]  redirect PC (branch ALU `PC_result`)
- `imem_req`  out  1  read request to instruction store
- `imem_addr`  out  [0:PC_W-1]  read word address
- `imem_rdata`  in  [0:INSTR_W-1]  read data, valid exactly one cycle after `imem_req`
- `instr_valid`  out  1  queue head valid
- `instr_ready`  in  1  decode accepts head
- `instr_out`  out  [0:INSTR_W-1]  head instruction
- `instr_pc`  out  [0:PC_W-1]  PC of head instruction (feeds branch ALU `in_PC`)

## Operation
- State: `fetch_pc`, FIFO (`QDEPTH` × {instr, pc}), `count`, `inflight` flag + `inflight_pc`, `epoch` bit with `inflight_epoch`.
- FSM: RUN, REDIRECT. REDIRECT lasts exactly one cycle after a taken branch, then RUN.
- Pop: `pop = instr_valid & instr_ready`. `instr_valid = (count != 0) & ~branch_taken` (gated combinationally; a head presented during a redirect cycle is never accepted).
- Issue (RUN only): `imem_req = fetch_en & ~branch_taken & (count + inflight - pop < QDEPTH)`; `imem_addr = fetch_pc`; on issue `fetch_pc <= fetch_pc + 1` mod 2^PC_W (1023 → 0), `inflight <= 1`, record pc and current epoch.
- Return: cycle after an issue, if `inflight_epoch == epoch`, push {`imem_rdata`, `inflight_pc`}; otherwise drop silently. No issue → `inflight <= 0`.
- Redirect (`branch_taken` high at an edge, any state): FIFO cleared (`count <= 0`, pointers reset), `epoch` toggles, `fetch_pc <= branch_target`, enter REDIRECT. Pop and push in that cycle are discarded.
- REDIRECT: `imem_req = fetch_en` at `fetch_pc` (target); a second `branch_taken` here re-applies redirect (latest target wins).
- `fetch_en` low: no new issues; in-flight return still completes; FIFO drains normally.
- Push and pop same cycle with FIFO full: legal, `count` unchanged. Credit rule makes overflow impossible; a push into a full FIFO is a design error (assertion).

## Timing
- Reset values: `imem_req`=0, `imem_addr`=0, `instr_valid`=0, `instr_out`=0, `instr_pc`=0, `fetch_pc`=0, `count`=0, `inflight`=0, `epoch`=0, FSM=RUN. Reset mid-operation clears all immediately; the return of any pre-reset request is ignored because `inflight`=0.
- First cycle after `rst_n` rises with `fetch_en`=1: `imem_req`=1, `imem_addr`=0; instruction 0 at head (`instr_valid`=1) the following cycle... i.e. fetch-to-head latency 2 edges after request issue: request at cycle N, pushed at edge end of N+1, valid in N+2.
- Steady state with `instr_ready`=1: one instruction per cycle, consecutive PCs.
- Redirect penalty: `branch_taken` in cycle T → target request in T+1 → target valid at head in T+3; `instr_valid`=0 in T..T+2.
- Backpressure: with `instr_ready`=0, FIFO fills to `QDEPTH` and `imem_req` stays 0 until a pop.

## Test plan
- Reset release, `fetch_en`=1, ready=1, imem returns data=pc: heads 0,1,2,… one per cycle, first `instr_valid` on 3rd cycle after reset release.
- Ready=0 for 10 cycles: exactly 4 requests (pcs 0–3), `count`=4, `imem_req`=0; raise ready → pops 0,1,2,3 then 4 follows with no gap.
- `branch_taken` with target 0x200 while pc 5 in flight and 3 queued: in-flight data dropped, queue empty, next head pc 0x200 exactly at T+3, then 0x201.
- `fetch_pc` at 1022, streaming: heads 1022, 1023, 0, 1.
- `branch_taken` in same cycle as ready=1 with non-empty queue: `instr_valid`=0 that cycle, no pop, next head = target; back-to-back branches in T and T+1 (targets 0x10, 0x40): head = 0x40.
- Assert `rst_n`=0 mid-stream with request outstanding: all outputs 0 immediately; after release, head sequence restarts at pc 0 with no stale instruction.
